// File: rtl/inter_side_link_scheduler.sv
// inter_side_link_scheduler
// Arbitrates the single link between the two decoder halves. The outgoing link
// carries data, control, status and credit-return words. The incoming link is
// demultiplexed to data/control outputs, or absorbed as status or credits.
// Optional feature macro: LINK_STATUS_HEARTBEAT_EN (periodic status resend).
module inter_side_link_scheduler #(
    parameter int DATA_WIDTH    = 20,
    parameter int CREDITS       = 8,
    parameter int STATUS_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dat_in_data,
    input  logic                  dat_in_valid,
    output logic                  dat_in_ready,
    input  logic [DATA_WIDTH-1:0] ctl_in_data,
    input  logic                  ctl_in_valid,
    output logic                  ctl_in_ready,
    output logic [DATA_WIDTH-1:0] dat_out_data,
    output logic                  dat_out_valid,
    input  logic                  dat_out_ready,
    output logic [DATA_WIDTH-1:0] ctl_out_data,
    output logic                  ctl_out_valid,
    input  logic                  ctl_out_ready,
    output logic [DATA_WIDTH+1:0] link_out_data,
    output logic                  link_out_valid,
    input  logic                  link_out_ready,
    input  logic [DATA_WIDTH+1:0] link_in_data,
    input  logic                  link_in_valid,
    output logic                  link_in_ready,
    input  logic                  has_message_flying_local,
    input  logic                  has_odd_clusters_local,
    output logic                  has_message_flying_otherside,
    output logic                  has_odd_clusters_otherside,
    output logic                  link_error
);

    localparam int CW    = $clog2(CREDITS + 1);
    localparam int SUM_W = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        T_DAT = 2'b00,
        T_CTL = 2'b01,
        T_STS = 2'b10,
        T_RET = 2'b11
    } link_type_t;

    // Reject parameter sets the datapath cannot represent.
    if (STATUS_PERIOD < 2 || CREDITS < 1 || DATA_WIDTH < 3) begin : g_param_check
        $error("inter_side_link_scheduler: unsupported parameter values");
    end

    logic                  r_out_valid;
    logic [DATA_WIDTH+1:0] r_out_data;
    logic [CW-1:0]         r_tx_credits;
    logic [CW-1:0]         r_pending_ret;
    logic                  r_status_due;
    logic [1:0]            r_last_status;
    logic                  r_rr_ctl;
    logic                  r_mf_other;
    logic                  r_odd_other;
    logic                  r_link_error;

    logic                  w_slot_free;
    logic                  w_grant_ret;
    logic                  w_grant_sts;
    logic                  w_dc_ok;
    logic                  w_grant_dat;
    logic                  w_grant_ctl;
    logic                  w_grant_dc;
    logic                  w_load;
    logic [DATA_WIDTH+1:0] w_load_word;
    logic [1:0]            w_local_status;
    logic [1:0]            w_rx_type;
    logic [DATA_WIDTH-1:0] w_rx_payload;
    logic                  w_consume;
    logic                  w_ret_rx;
    logic                  w_sts_rx;
    logic [SUM_W-1:0]      w_credit_sum;
    logic                  w_credit_over;
    logic [CW-1:0]         w_pending_inc;
    logic                  w_hb_tick;

    // Slot arbitration: credit returns first so the far side never starves,
    // then status, then data/control sharing the remaining credits fairly.
    assign w_slot_free = !r_out_valid || link_out_ready;
    assign w_grant_ret = w_slot_free && (r_pending_ret != '0);
    assign w_grant_sts = w_slot_free && !w_grant_ret && r_status_due;
    assign w_dc_ok     = w_slot_free && !w_grant_ret && !r_status_due && (r_tx_credits != '0);
    assign w_grant_dat = w_dc_ok && dat_in_valid && (!ctl_in_valid || !r_rr_ctl);
    assign w_grant_ctl = w_dc_ok && ctl_in_valid && (!dat_in_valid || r_rr_ctl);
    assign w_grant_dc  = w_grant_dat || w_grant_ctl;
    assign w_load      = w_grant_ret || w_grant_sts || w_grant_dc;

    assign dat_in_ready = w_grant_dat;
    assign ctl_in_ready = w_grant_ctl;

    assign w_local_status = {has_odd_clusters_local, has_message_flying_local};

    // Build the word that enters the output stage this cycle.
    always_comb begin
        w_load_word = '0;
        if (w_grant_ret) begin
            w_load_word = {T_RET, DATA_WIDTH'(r_pending_ret)};
        end else if (w_grant_sts) begin
            w_load_word = {T_STS, DATA_WIDTH'(w_local_status)};
        end else if (w_grant_dat) begin
            w_load_word = {T_DAT, dat_in_data};
        end else if (w_grant_ctl) begin
            w_load_word = {T_CTL, ctl_in_data};
        end
    end

    // Receive side: steer by type code; status and credit words are always taken.
    assign w_rx_type    = link_in_data[DATA_WIDTH+1:DATA_WIDTH];
    assign w_rx_payload = link_in_data[DATA_WIDTH-1:0];
    assign dat_out_data  = w_rx_payload;
    assign ctl_out_data  = w_rx_payload;
    assign dat_out_valid = link_in_valid && (w_rx_type == T_DAT);
    assign ctl_out_valid = link_in_valid && (w_rx_type == T_CTL);
    assign w_ret_rx      = link_in_valid && (w_rx_type == T_RET);
    assign w_sts_rx      = link_in_valid && (w_rx_type == T_STS);
    assign w_consume     = (dat_out_valid && dat_out_ready) || (ctl_out_valid && ctl_out_ready);

    // Select link_in_ready according to the incoming word type.
    always_comb begin
        link_in_ready = 1'b1;
        case (w_rx_type)
            T_DAT:   link_in_ready = dat_out_ready;
            T_CTL:   link_in_ready = ctl_out_ready;
            default: link_in_ready = 1'b1;
        endcase
    end

    // Credit arithmetic is done wide so an oversized return is detectable.
    assign w_credit_sum  = SUM_W'(r_tx_credits)
                         + (w_ret_rx ? SUM_W'(w_rx_payload) : '0)
                         - SUM_W'(w_grant_dc);
    assign w_credit_over = (w_credit_sum > SUM_W'(CREDITS));
    assign w_pending_inc = (r_pending_ret == CW'(CREDITS)) ? r_pending_ret
                                                           : r_pending_ret + CW'(1);

`ifdef LINK_STATUS_HEARTBEAT_EN
    localparam int HW = $clog2(STATUS_PERIOD);
    logic [HW-1:0] r_hb_timer;

    assign w_hb_tick = (r_hb_timer == HW'(STATUS_PERIOD - 1));

    // Heartbeat timer, restarted whenever a status word goes out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hb_timer <= '0;
        end else if (w_grant_sts || w_hb_tick) begin
            r_hb_timer <= '0;
        end else begin
            r_hb_timer <= r_hb_timer + HW'(1);
        end
    end
`else
    assign w_hb_tick = 1'b0;
`endif

    // Output stage valid flag; a reset discards any held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
        end else if (link_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output stage payload; only meaningful while r_out_valid is set.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_out_data <= w_load_word;
        end
    end

    // Credit bookkeeping in both directions plus the sticky overflow error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_credits  <= CW'(CREDITS);
            r_pending_ret <= '0;
            r_link_error  <= 1'b0;
        end else begin
            r_tx_credits <= w_credit_over ? CW'(CREDITS) : w_credit_sum[CW-1:0];
            if (w_credit_over) begin
                r_link_error <= 1'b1;
            end
            if (w_grant_ret) begin
                r_pending_ret <= w_consume ? CW'(1) : '0;
            end else if (w_consume) begin
                r_pending_ret <= w_pending_inc;
            end
        end
    end

    // Status scheduling and round-robin pointer between data and control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status_due  <= 1'b1;
            r_last_status <= 2'b00;
            r_rr_ctl      <= 1'b0;
        end else begin
            if (w_grant_sts) begin
                r_status_due  <= 1'b0;
                r_last_status <= w_local_status;
            end else if ((w_local_status != r_last_status) || w_hb_tick) begin
                r_status_due <= 1'b1;
            end
            if (w_grant_dat) begin
                r_rr_ctl <= 1'b1;
            end else if (w_grant_ctl) begin
                r_rr_ctl <= 1'b0;
            end
        end
    end

    // Capture the far side's status; assume busy until told otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mf_other  <= 1'b1;
            r_odd_other <= 1'b1;
        end else if (w_sts_rx) begin
            r_mf_other  <= w_rx_payload[0];
            r_odd_other <= w_rx_payload[1];
        end
    end

    assign link_out_valid               = r_out_valid;
    assign link_out_data                = r_out_data;
    assign has_message_flying_otherside = r_mf_other;
    assign has_odd_clusters_otherside   = r_odd_other;
    assign link_error                   = r_link_error;

endmodule

// File: tb/tb_inter_side_link_scheduler.sv
// Bench for inter_side_link_scheduler: directed phases, a transaction-level
// reference model checked every cycle, and literal expectations per phase.
module tb_inter_side_link_scheduler;

    localparam int DW = 20;
    localparam int CR = 8;
    localparam int SP = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dat_in_data, ctl_in_data;
    logic          dat_in_valid, ctl_in_valid;
    logic          dat_in_ready, ctl_in_ready;
    logic [DW-1:0] dat_out_data, ctl_out_data;
    logic          dat_out_valid, ctl_out_valid;
    logic          dat_out_ready, ctl_out_ready;
    logic [DW+1:0] link_out_data, link_in_data;
    logic          link_out_valid, link_out_ready;
    logic          link_in_valid, link_in_ready;
    logic          mf_local, odd_local;
    logic          mf_other, odd_other, link_error;

    always #5 clk = ~clk;

    inter_side_link_scheduler #(.DATA_WIDTH(DW), .CREDITS(CR), .STATUS_PERIOD(SP)) dut (
        .clk(clk), .reset(reset),
        .dat_in_data(dat_in_data), .dat_in_valid(dat_in_valid), .dat_in_ready(dat_in_ready),
        .ctl_in_data(ctl_in_data), .ctl_in_valid(ctl_in_valid), .ctl_in_ready(ctl_in_ready),
        .dat_out_data(dat_out_data), .dat_out_valid(dat_out_valid), .dat_out_ready(dat_out_ready),
        .ctl_out_data(ctl_out_data), .ctl_out_valid(ctl_out_valid), .ctl_out_ready(ctl_out_ready),
        .link_out_data(link_out_data), .link_out_valid(link_out_valid), .link_out_ready(link_out_ready),
        .link_in_data(link_in_data), .link_in_valid(link_in_valid), .link_in_ready(link_in_ready),
        .has_message_flying_local(mf_local), .has_odd_clusters_local(odd_local),
        .has_message_flying_otherside(mf_other), .has_odd_clusters_otherside(odd_other),
        .link_error(link_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the link must look like from the outside.
    bit          m_valid;
    logic [DW+1:0] m_word;
    int          m_credits, m_pending, m_hb;
    bit          m_due, m_rr_ctl, m_mf, m_odd, m_err;
    logic [1:0]  m_last;

    logic [DW+1:0] sent[$];

    task automatic model_reset();
        m_valid = 0; m_word = '0; m_credits = CR; m_pending = 0; m_hb = 0;
        m_due = 1; m_rr_ctl = 0; m_mf = 1; m_odd = 1; m_err = 0; m_last = 2'b00;
    endtask

    // Per-cycle scratch used only by the compare process.
    int         kind, rx_p, newc;
    logic [1:0] rx_t;
    bit         slot_free, consumed, exp_lir;

    // Compare DUT against the model mid-cycle, then advance the model with the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (reset) model_reset();
        rx_t = link_in_data[DW+1:DW];
        rx_p = int'(link_in_data[DW-1:0]);
        slot_free = !m_valid || link_out_ready;
        kind = 0;
        if (slot_free) begin
            if (m_pending > 0) kind = 1;
            else if (m_due) kind = 2;
            else if (m_credits > 0) begin
                if (dat_in_valid && ctl_in_valid) kind = m_rr_ctl ? 4 : 3;
                else if (dat_in_valid) kind = 3;
                else if (ctl_in_valid) kind = 4;
            end
        end
        exp_lir = (rx_t == 2'b00) ? dat_out_ready : (rx_t == 2'b01) ? ctl_out_ready : 1'b1;

        check("link_out_valid", link_out_valid, m_valid);
        if (m_valid) check("link_out_data", link_out_data, m_word);
        check("dat_in_ready", dat_in_ready, kind == 3);
        check("ctl_in_ready", ctl_in_ready, kind == 4);
        check("link_in_ready", link_in_ready, exp_lir);
        check("dat_out_valid", dat_out_valid, link_in_valid && rx_t == 2'b00);
        check("ctl_out_valid", ctl_out_valid, link_in_valid && rx_t == 2'b01);
        if (link_in_valid && rx_t == 2'b00) check("dat_out_data", dat_out_data, rx_p);
        if (link_in_valid && rx_t == 2'b01) check("ctl_out_data", ctl_out_data, rx_p);
        check("mf_otherside", mf_other, m_mf);
        check("odd_otherside", odd_other, m_odd);
        check("link_error", link_error, m_err);

        if (!reset) begin
            if (link_out_valid && link_out_ready) sent.push_back(link_out_data);
            consumed = link_in_valid && ((rx_t == 2'b00 && dat_out_ready) ||
                                         (rx_t == 2'b01 && ctl_out_ready));
            newc = m_credits - ((kind >= 3) ? 1 : 0) + ((link_in_valid && rx_t == 2'b11) ? rx_p : 0);
            if (newc > CR) begin newc = CR; m_err = 1; end
            m_credits = newc;
            case (kind)
                1: m_word = {2'b11, DW'(m_pending)};
                2: m_word = {2'b10, DW'({odd_local, mf_local})};
                3: m_word = {2'b00, dat_in_data};
                4: m_word = {2'b01, ctl_in_data};
                default: ;
            endcase
            if (kind != 0) m_valid = 1;
            else if (link_out_ready) m_valid = 0;
            if (kind == 1) m_pending = consumed ? 1 : 0;
            else if (consumed && m_pending < CR) m_pending++;
            if (kind == 2) begin
                m_due = 0; m_last = {odd_local, mf_local};
            end else if ({odd_local, mf_local} != m_last) m_due = 1;
`ifdef LINK_STATUS_HEARTBEAT_EN
            if (kind == 2) m_hb = 0;
            else if (m_hb == SP - 1) begin m_hb = 0; m_due = 1; end
            else m_hb++;
`endif
            if (kind == 3) m_rr_ctl = 1;
            if (kind == 4) m_rr_ctl = 0;
            if (link_in_valid && rx_t == 2'b10) begin m_mf = link_in_data[0]; m_odd = link_in_data[1]; end
        end
    end

    // Free-running source payloads so every accepted word is distinct.
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        dat_in_data <= DW'(cyc);
        ctl_in_data <= DW'(cyc) ^ 20'hABCDE;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_in(input logic [1:0] t, input int p);
        link_in_data = {t, DW'(p)}; link_in_valid = 1; tick(1); link_in_valid = 0;
    endtask

    int n_t0, n_t1, n_t2, n_t3, sum_ret;
    logic [DW+1:0] w;

    task automatic tally();
        n_t0 = 0; n_t1 = 0; n_t2 = 0; n_t3 = 0; sum_ret = 0;
        foreach (sent[i]) begin
            w = sent[i];
            case (w[DW+1:DW])
                2'b00: n_t0++;
                2'b01: n_t1++;
                2'b10: n_t2++;
                default: begin n_t3++; sum_ret += int'(w[DW-1:0]); end
            endcase
        end
    endtask

    initial begin
        reset = 1; dat_in_valid = 0; ctl_in_valid = 0;
        dat_out_ready = 1; ctl_out_ready = 1; link_out_ready = 1;
        link_in_data = '0; link_in_valid = 0; mf_local = 1; odd_local = 0;
        tick(2);
        check("rst_out_valid", link_out_valid, 0);
        check("rst_mf_other", mf_other, 1);
        check("rst_odd_other", odd_other, 1);
        check("rst_link_error", link_error, 0);

        // Status word after reset, then idle.
        reset = 0; sent.delete(); tick(6);
        check("boot_words", sent.size(), 1);
        w = (sent.size() > 0) ? sent[0] : '1;
        check("boot_word", w, 22'h200001);

        // Both classes contend until credits run out.
        sent.delete(); dat_in_valid = 1; ctl_in_valid = 1; tick(20);
        check("exhaust_dat_ready", dat_in_ready, 0);
        check("exhaust_ctl_ready", ctl_in_ready, 0);
        tally();
        check("exhaust_total", sent.size(), 8);
        check("exhaust_dat", n_t0, 4);
        check("exhaust_ctl", n_t1, 4);
        w = (sent.size() > 1) ? sent[1] : '0;
        check("alt_second_ctl", w[DW+1:DW], 2'b01);
        w = (sent.size() > 0) ? sent[0] : '1;
        check("alt_first_dat", w[DW+1:DW], 2'b00);

        // Three credits back give exactly three words.
        sent.delete(); send_in(2'b11, 3); tick(15);
        check("ret3_words", sent.size(), 3);
        dat_in_valid = 0; ctl_in_valid = 0; tick(2);

        // Refill to full, then overflow.
        send_in(2'b11, 8); tick(2);
        check("refill_no_error", link_error, 0);
        send_in(2'b11, 5); tick(2);
        check("overflow_error", link_error, 1);
        tick(5);
        check("error_sticky", link_error, 1);
        sent.delete(); dat_in_valid = 1; tick(15); dat_in_valid = 0;
        check("saturated_words", sent.size(), 8);

        // Receive four data words; one stalled cycle first.
        tick(2); sent.delete();
        dat_out_ready = 0; link_in_data = {2'b00, 20'h00100}; link_in_valid = 1; tick(1);
        dat_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            link_in_data = {2'b00, DW'(32'h200 + i)}; link_in_valid = 1; tick(1);
        end
        link_in_valid = 0; tick(8);
        tally();
        check("ret_sum", sum_ret, 4);
        check("ret_only", sent.size(), n_t3);
        send_in(2'b01, 20'h12345); send_in(2'b10, 2); tick(3);
        check("sts_rx_mf", mf_other, 0);
        check("sts_rx_odd", odd_other, 1);

        // Held status word while the link is back-pressured.
        link_out_ready = 0; mf_local = 0; tick(3);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", link_out_valid, 1);
            check("hold_data", link_out_data, 22'h200000);
            tick(1);
        end
        sent.delete(); link_out_ready = 1; tick(25);
        tally();
`ifdef LINK_STATUS_HEARTBEAT_EN
        check("hold_heartbeat", n_t2 >= 2, 1);
`else
        check("hold_sts_once", n_t2, 1);
        check("hold_then_idle", sent.size(), 1);
`endif

        // Reset while a data word is held drops it.
        link_out_ready = 0; send_in(2'b11, 2); dat_in_valid = 1; tick(3);
        check("pre_reset_valid", link_out_valid, 1);
        reset = 1; #1;
        check("midreset_valid", link_out_valid, 0);
        dat_in_valid = 0; link_out_ready = 1; tick(2);
        reset = 0; tick(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
